// File: rtl/m_stage_pipe.sv
// m_stage_pipe: NUM_STAGES-deep register pipeline with bubble-collapsing stall,
// selective kill by ROB id, flush, and a registered occupancy count.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WITDH
`define ROB_ENTRY_WITDH 6
`endif

module m_stage_pipe #(
  parameter int unsigned WORD_SIZE       = `WORD_SIZE,
  parameter int unsigned INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
  parameter int unsigned ROB_ENTRY_WITDH = `ROB_ENTRY_WITDH,
  parameter int unsigned NUM_STAGES      = 4,
  localparam int unsigned OCC_W          = $clog2(NUM_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  input  logic [WORD_SIZE-1:0]       pc,
  input  logic [WORD_SIZE-1:0]       result,
  input  logic [ROB_ENTRY_WITDH-1:0] rob_id,
  input  logic                       valid,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       kill_valid,
  input  logic [ROB_ENTRY_WITDH-1:0] kill_rob_id,
  output logic [INSTR_TYPE_SZ-1:0]   instruction_type_out,
  output logic [WORD_SIZE-1:0]       pc_out,
  output logic [WORD_SIZE-1:0]       result_out,
  output logic [ROB_ENTRY_WITDH-1:0] rob_id_out,
  output logic                       valid_out,
  output logic                       ready_out,
  output logic [OCC_W-1:0]           occupancy
);

  localparam int NS = int'(NUM_STAGES);

  // Stage registers, index 0 is the input side.
  logic [NUM_STAGES-1:0]                      v_q, v_d;
  logic [NUM_STAGES-1:0][INSTR_TYPE_SZ-1:0]   it_q, it_d;
  logic [NUM_STAGES-1:0][WORD_SIZE-1:0]       pc_q, pc_d;
  logic [NUM_STAGES-1:0][WORD_SIZE-1:0]       res_q, res_d;
  logic [NUM_STAGES-1:0][ROB_ENTRY_WITDH-1:0] rob_q, rob_d;
  logic [OCC_W-1:0]                           occ_q, occ_d;

  // Per-stage source (previous stage, or the inputs for stage 0).
  logic [NUM_STAGES-1:0]                      src_v;
  logic [NUM_STAGES-1:0][INSTR_TYPE_SZ-1:0]   src_it;
  logic [NUM_STAGES-1:0][WORD_SIZE-1:0]       src_pc;
  logic [NUM_STAGES-1:0][WORD_SIZE-1:0]       src_res;
  logic [NUM_STAGES-1:0][ROB_ENTRY_WITDH-1:0] src_rob;

  logic [NUM_STAGES-1:0] en;

  // Load enables: a stage moves if the stage after it moves or it is empty.
  // Accumulated from the output side so no vector feeds back on itself.
  always_comb begin
    logic acc;
    acc            = !stall || !v_q[NS-1];
    en             = '0;
    en[NS-1]       = acc;
    for (int i = NS - 2; i >= 0; i--) begin
      acc   = acc || !v_q[i];
      en[i] = acc;
    end
  end

  // Source selection for every stage.
  always_comb begin
    src_v      = '0;
    src_it     = '0;
    src_pc     = '0;
    src_res    = '0;
    src_rob    = '0;
    src_v[0]   = valid;
    src_it[0]  = instruction_type;
    src_pc[0]  = pc;
    src_res[0] = result;
    src_rob[0] = rob_id;
    for (int i = 1; i < NS; i++) begin
      src_v[i]   = v_q[i-1];
      src_it[i]  = it_q[i-1];
      src_pc[i]  = pc_q[i-1];
      src_res[i] = res_q[i-1];
      src_rob[i] = rob_q[i-1];
    end
  end

  // Next state: movement first, then kill mask on the moved ids, then flush.
  always_comb begin
    v_d   = v_q;
    it_d  = it_q;
    pc_d  = pc_q;
    res_d = res_q;
    rob_d = rob_q;
    occ_d = '0;
    for (int i = 0; i < NS; i++) begin
      if (en[i]) begin
        v_d[i] = src_v[i];
        // Payload only follows a real entry; bubbles leave stale payload in place.
        if (src_v[i]) begin
          it_d[i]  = src_it[i];
          pc_d[i]  = src_pc[i];
          res_d[i] = src_res[i];
          rob_d[i] = src_rob[i];
        end
      end
    end
    if (kill_valid) begin
      for (int i = 0; i < NS; i++) begin
        if (rob_d[i] == kill_rob_id) begin
          v_d[i] = 1'b0;
        end
      end
    end
    if (flush) begin
      v_d = '0;
    end
    for (int i = 0; i < NS; i++) begin
      occ_d = occ_d + OCC_W'(v_d[i]);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q   <= '0;
      it_q  <= '0;
      pc_q  <= '0;
      res_q <= '0;
      rob_q <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      it_q  <= it_d;
      pc_q  <= pc_d;
      res_q <= res_d;
      rob_q <= rob_d;
      occ_q <= occ_d;
    end
  end

  assign instruction_type_out = it_q[NS-1];
  assign pc_out               = pc_q[NS-1];
  assign result_out           = res_q[NS-1];
  assign rob_id_out           = rob_q[NS-1];
  assign valid_out            = v_q[NS-1];
  assign ready_out            = en[0];
  assign occupancy            = occ_q;

endmodule

// File: tb/tb_m_stage_pipe.sv
// Directed bench for m_stage_pipe with NUM_STAGES=4.
module tb_m_stage_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  instruction_type = '0;
  logic [31:0] pc = '0;
  logic [31:0] result = '0;
  logic [5:0]  rob_id = '0;
  logic        valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        kill_valid = 1'b0;
  logic [5:0]  kill_rob_id = '0;
  logic [3:0]  instruction_type_out;
  logic [31:0] pc_out;
  logic [31:0] result_out;
  logic [5:0]  rob_id_out;
  logic        valid_out;
  logic        ready_out;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  m_stage_pipe #(
    .WORD_SIZE      (32),
    .INSTR_TYPE_SZ  (4),
    .ROB_ENTRY_WITDH(6),
    .NUM_STAGES     (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .instruction_type    (instruction_type),
    .pc                  (pc),
    .result              (result),
    .rob_id              (rob_id),
    .valid               (valid),
    .stall               (stall),
    .flush               (flush),
    .kill_valid          (kill_valid),
    .kill_rob_id         (kill_rob_id),
    .instruction_type_out(instruction_type_out),
    .pc_out              (pc_out),
    .result_out          (result_out),
    .rob_id_out          (rob_id_out),
    .valid_out           (valid_out),
    .ready_out           (ready_out),
    .occupancy           (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [5:0] r);
    valid            = v;
    pc               = p;
    result           = p ^ 32'hA5A5_0000;
    rob_id           = r;
    instruction_type = r[3:0];
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid_out: got %0b want 0", valid_out);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready_out: got %0b want 1", ready_out);
    end
    checks++;
    if (occupancy !== 3'd0) begin
      errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    end
    checks++;
    if (pc_out !== 32'h0) begin
      errors++; $display("FAIL reset_pc_out: got %h want 0", pc_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 6'(k + 1));
      step();
      if (k == 2) begin
        checks++;
        if (valid_out !== 1'b0 || occupancy !== 3'd3) begin
          errors++;
          $display("FAIL stream_edge3: valid_out %0b occ %0d want 0 3", valid_out, occupancy);
        end
      end
      if (k == 3) begin
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h100 || occupancy !== 3'd4) begin
          errors++;
          $display("FAIL stream_edge4: valid %0b pc %h occ %0d want 1 100 4",
                   valid_out, pc_out, occupancy);
        end
        checks++;
        if (result_out !== 32'hA5A5_0100 || instruction_type_out !== 4'd1 ||
            rob_id_out !== 6'd1) begin
          errors++;
          $display("FAIL stream_payload: res %h it %0d rob %0d want a5a50100 1 1",
                   result_out, instruction_type_out, rob_id_out);
        end
      end
      if (k == 4) begin
        checks++;
        if (pc_out !== 32'h104) begin
          errors++; $display("FAIL stream_edge5: pc %h want 104", pc_out);
        end
      end
      if (k == 5) begin
        checks++;
        if (pc_out !== 32'h108 || occupancy !== 3'd4) begin
          errors++; $display("FAIL stream_edge6: pc %h occ %0d want 108 4", pc_out, occupancy);
        end
      end
    end
  endtask

  // Pipe is full with 0x108..0x114 when this starts.
  task automatic test_backpressure();
    drive(1'b1, 32'h118, 6'd7);
    stall = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++; $display("FAIL bp_ready: got %0b want 0", ready_out);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (pc_out !== 32'h108 || valid_out !== 1'b1 || occupancy !== 3'd4) begin
        errors++;
        $display("FAIL bp_hold%0d: pc %h valid %0b occ %0d want 108 1 4",
                 k, pc_out, valid_out, occupancy);
      end
    end
    stall = 1'b0;
    drive(1'b0, 32'h0, 6'd0);
    step();
    checks++;
    if (pc_out !== 32'h10C) begin
      errors++; $display("FAIL bp_release: pc %h want 10c", pc_out);
    end
    step();
    step();
    checks++;
    if (pc_out !== 32'h114 || valid_out !== 1'b1) begin
      errors++; $display("FAIL bp_last: pc %h valid %0b want 114 1", pc_out, valid_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL bp_not_captured: valid %0b occ %0d want 0 0", valid_out, occupancy);
    end
  endtask

  task automatic test_bubble_collapse();
    drive(1'b1, 32'h200, 6'd10); step();
    drive(1'b0, 32'h0, 6'd0);    step();
    drive(1'b1, 32'h204, 6'd11); step();
    drive(1'b0, 32'h0, 6'd0);    step();
    checks++;
    if (occupancy !== 3'd2 || pc_out !== 32'h200) begin
      errors++; $display("FAIL bubble_setup: occ %0d pc %h want 2 200", occupancy, pc_out);
    end
    stall = 1'b1;
    drive(1'b1, 32'h208, 6'd12);
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL bubble_ready: got %0b want 1", ready_out);
    end
    step();
    checks++;
    if (pc_out !== 32'h200 || valid_out !== 1'b1 || occupancy !== 3'd3) begin
      errors++;
      $display("FAIL bubble_stall: pc %h valid %0b occ %0d want 200 1 3",
               pc_out, valid_out, occupancy);
    end
    stall = 1'b0;
    drive(1'b0, 32'h0, 6'd0);
    step();
    checks++;
    if (pc_out !== 32'h204 || valid_out !== 1'b1) begin
      errors++; $display("FAIL bubble_s2: pc %h valid %0b want 204 1", pc_out, valid_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL bubble_gap: valid %0b want 0", valid_out);
    end
    step();
    checks++;
    if (pc_out !== 32'h208 || valid_out !== 1'b1) begin
      errors++; $display("FAIL bubble_s0: pc %h valid %0b want 208 1", pc_out, valid_out);
    end
    step();
    checks++;
    if (occupancy !== 3'd0) begin
      errors++; $display("FAIL bubble_drain: occ %0d want 0", occupancy);
    end
  endtask

  task automatic test_kill();
    drive(1'b1, 32'h300, 6'd5); step();
    drive(1'b1, 32'h304, 6'd6); step();
    drive(1'b1, 32'h308, 6'd7); step();
    checks++;
    if (occupancy !== 3'd3) begin
      errors++; $display("FAIL kill_setup: occ %0d want 3", occupancy);
    end
    drive(1'b1, 32'h30C, 6'd5);
    kill_valid  = 1'b1;
    kill_rob_id = 6'd5;
    step();
    kill_valid = 1'b0;
    drive(1'b0, 32'h0, 6'd0);
    checks++;
    if (occupancy !== 3'd2 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL kill_edge: occ %0d valid %0b want 2 0", occupancy, valid_out);
    end
    step();
    checks++;
    if (pc_out !== 32'h304 || rob_id_out !== 6'd6 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL kill_survivor6: pc %h rob %0d valid %0b want 304 6 1",
               pc_out, rob_id_out, valid_out);
    end
    step();
    checks++;
    if (pc_out !== 32'h308 || valid_out !== 1'b1) begin
      errors++; $display("FAIL kill_survivor7: pc %h valid %0b want 308 1", pc_out, valid_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL kill_input_dropped: valid %0b occ %0d want 0 0", valid_out, occupancy);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h400 + 32'(4 * k), 6'(20 + k));
      step();
    end
    checks++;
    if (occupancy !== 3'd4) begin
      errors++; $display("FAIL flush_setup: occ %0d want 4", occupancy);
    end
    stall = 1'b1;
    drive(1'b1, 32'h410, 6'd24);
    flush = 1'b1;
    step();
    checks++;
    if (valid_out !== 1'b0 || occupancy !== 3'd0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_edge: valid %0b occ %0d ready %0b want 0 0 1",
               valid_out, occupancy, ready_out);
    end
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h0, 6'd0);
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (valid_out !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL flush_after: valid %0b occ %0d want 0 0", valid_out, occupancy);
    end
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h500 + 32'(4 * k), 6'(40 + k));
      step();
    end
    checks++;
    if (occupancy !== 3'd4 || pc_out !== 32'h500) begin
      errors++; $display("FAIL rst_setup: occ %0d pc %h want 4 500", occupancy, pc_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || occupancy !== 3'd0 || pc_out !== 32'h0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: valid %0b occ %0d pc %h ready %0b want 0 0 0 1",
               valid_out, occupancy, pc_out, ready_out);
    end
    #1;
    reset = 1'b1;
    drive(1'b1, 32'h600, 6'd50);
    step();
    drive(1'b0, 32'h0, 6'd0);
    checks++;
    if (occupancy !== 3'd1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_resume: occ %0d valid %0b want 1 0", occupancy, valid_out);
    end
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (pc_out !== 32'h600 || valid_out !== 1'b1) begin
      errors++; $display("FAIL rst_resume_out: pc %h valid %0b want 600 1", pc_out, valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble_collapse();
    test_kill();
    test_flush();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_stage_pipe.md
M_STAGE_PIPE -- requirements
Module: m_stage_pipe

Interface
REQ-001 SHALL have parameter WORD_SIZE, default `WORD_SIZE, width of pc/result.
REQ-002 SHALL have parameter INSTR_TYPE_SZ, default `INSTR_TYPE_SZ, width of instruction_type.
REQ-003 SHALL have parameter ROB_ENTRY_WITDH, default `ROB_ENTRY_WITDH, width of rob_id.
REQ-004 SHALL have parameter NUM_STAGES, default 4, pipeline depth (legal range 1..16).
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1; asynchronous, active-low.
REQ-007 SHALL have port instruction_type, input, INSTR_TYPE_SZ, payload into stage 0.
REQ-008 SHALL have port pc, input, WORD_SIZE, payload into stage 0.
REQ-009 SHALL have port result, input, WORD_SIZE, payload into stage 0.
REQ-010 SHALL have port rob_id, input, ROB_ENTRY_WITDH, payload into stage 0.
REQ-011 SHALL have port valid, input, 1, upstream entry present.
REQ-012 SHALL have port stall, input, 1, downstream cannot accept output entry.
REQ-013 SHALL have port flush, input, 1, kill every entry, including the incoming one.
REQ-014 SHALL have port kill_valid, input, 1, selective kill request.
REQ-015 SHALL have port kill_rob_id, input, ROB_ENTRY_WITDH, ROB id to kill.
REQ-016 SHALL have ports instruction_type_out, pc_out, result_out, rob_id_out, valid_out, outputs, widths as the matching inputs, last stage contents.
REQ-017 SHALL have port ready_out, output, 1, stage 0 accepts an entry this cycle.
REQ-018 SHALL have port occupancy, output, $clog2(NUM_STAGES+1), count of valid stages.

Function
REQ-019 SHALL hold NUM_STAGES register stages, S0 (input side) to S[N-1] (output side); each stage holds v plus the four payload fields.
REQ-020 SHALL compute enables combinationally: en[N-1] = !stall || !v[N-1]; en[i] = en[i+1] || !v[i]. Stalls collapse bubbles; an empty stage always loads.
REQ-021 SHALL load S[i] from S[i-1] (S0 from the inputs) when en[i] is 1. Stage v takes the source valid. Payload is written only when the source valid is 1; otherwise the payload holds.
REQ-022 SHALL leave a stage unchanged when its en is 0.
REQ-023 SHALL drive ready_out = en[0] combinationally. When valid=1 and ready_out=0, the entry is not captured and upstream holds it.
REQ-024 SHALL have a latency of NUM_STAGES edges with no stall: a valid captured at edge k appears at valid_out after edge k+NUM_STAGES-1.
REQ-025 SHALL on flush=1 clear every v at the edge and drop the incoming entry. Flush has priority over load and over kill.
REQ-026 SHALL on kill_valid=1 clear the next-state v of any stage whose next-state rob_id equals kill_rob_id, including an entry being captured from the inputs. Payload is unaffected.
REQ-027 SHALL treat simultaneous stall, kill and load as follows: first apply movement per REQ-020/021, then the kill mask, then flush.
REQ-028 SHALL register occupancy as the popcount of the next-state v bits; range 0..NUM_STAGES, no wrap.
REQ-029 SHALL drive the *_out ports directly from the S[N-1] registers (registered outputs, no combinational input-to-output path).
REQ-030 SHALL behave, for NUM_STAGES=1, as a single register stage with bubble-aware stall.

Reset
REQ-031 SHALL, while reset=0, immediately clear all v, all payloads, and occupancy to 0, independent of clk.
REQ-032 SHALL give valid_out=0, ready_out=1 and occupancy=0 during reset; a reset asserted mid-operation discards all in-flight entries.
REQ-033 SHALL resume loading at the first rising edge after reset returns to 1.

Verification
REQ-034 SHALL cover streaming with N=4, stall=0, valid=1, pc=0x100,0x104,... -> pc_out=0x100 with valid_out=1 after the 4th edge, one entry per cycle thereafter, occupancy=4.
REQ-035 SHALL cover bubble collapse: N=4, entries at S3 and S1 only, stall=1 for 1 cycle -> S3 holds; S1 advances to S2; S0 loads; ready_out=1; occupancy 2->3.
REQ-036 SHALL cover full backpressure: all 4 stages valid, stall=1 -> ready_out=0, the held input is not captured, the outputs are stable, occupancy=4.
REQ-037 SHALL cover selective kill: rob_id 5 in S2 and at the inputs, kill_valid=1, kill_rob_id=5 -> both v cleared, other entries advance, occupancy reduced by 1 (the input is not counted).
REQ-038 SHALL cover flush while stall=1 and valid=1 -> all v=0 after the edge, occupancy=0, ready_out=1.
REQ-039 SHALL cover reset=0 pulsed between clock edges while full -> valid_out=0 and occupancy=0 with no clock edge; pc_out=0.
